// File: rtl/brianhg_gfx_pkg.sv
// Shared types and helpers for the line fetch path.
package brianhg_gfx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } fetch_state_t;

    // Length of the next burst: whatever is left, capped at the max burst size.
    function automatic int unsigned burst_len(input int unsigned words,
                                              input int unsigned max_burst);
        return (words < max_burst) ? words : max_burst;
    endfunction

endpackage

// File: rtl/brianhg_gfx_edge_det.sv
// Registered copy of a level plus rising/falling edge strobes against it.
module brianhg_gfx_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    // One-cycle delayed copy of the input level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) d_q <= 1'b0;
        else     d_q <= d;
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/brianhg_gfx_line_fetch.sv
// Per-line DDR3 read request generator driven by the sync generator enables.
module brianhg_gfx_line_fetch
    import brianhg_gfx_pkg::*;
#(
    parameter int HC_BITS    = 16,
    parameter int ADDR_BITS  = 32,
    parameter int WORD_BYTES = 16,
    parameter int MAX_BURST  = 32,
    parameter int LEN_BITS   = 9
) (
    input  logic                 CLK_IN,
    input  logic                 reset,
    input  logic                 ENABLE,
    input  logic                 H_ena,
    input  logic                 V_ena,
    input  logic [ADDR_BITS-1:0] BASE_ADDR,
    input  logic [ADDR_BITS-1:0] LINE_STRIDE,
    input  logic [HC_BITS-1:0]   LINE_WORDS,
    output logic                 CMD_req,
    output logic [ADDR_BITS-1:0] CMD_addr,
    output logic [LEN_BITS-1:0]  CMD_len,
    input  logic                 CMD_ready,
    output logic                 BUSY,
    output logic                 LINE_DONE,
    output logic [HC_BITS-1:0]   LINE_NUM,
    output logic                 LATE_ERR
);

    fetch_state_t         state, state_nxt;
    logic                 h_fall, v_rise, h_rise_unused, v_fall_unused;
    logic                 frame_start, trigger, accept, last;
    logic [ADDR_BITS-1:0] cur_addr, next_addr, line_addr, step;
    logic [HC_BITS-1:0]   words_left, line_cnt, line_idx;

    brianhg_gfx_edge_det u_h_edge (
        .clk  (CLK_IN),
        .rst  (reset),
        .d    (H_ena),
        .rise (h_rise_unused),
        .fall (h_fall)
    );

    brianhg_gfx_edge_det u_v_edge (
        .clk  (CLK_IN),
        .rst  (reset),
        .d    (V_ena),
        .rise (v_rise),
        .fall (v_fall_unused)
    );

    assign frame_start = v_rise;
    assign trigger     = h_fall & V_ena & ENABLE;
    // A frame start in the trigger cycle means this is line 0 at BASE_ADDR.
    assign line_addr   = frame_start ? BASE_ADDR : next_addr;
    assign line_idx    = frame_start ? '0 : line_cnt;

    assign CMD_req  = (state == ISSUE);
    assign BUSY     = (state == ISSUE);
    assign CMD_addr = cur_addr;
    assign CMD_len  = LEN_BITS'(burst_len(32'(words_left), MAX_BURST));
    assign accept   = CMD_req & CMD_ready;
    assign last     = (words_left == HC_BITS'(CMD_len));
    assign step     = ADDR_BITS'(CMD_len) * ADDR_BITS'(WORD_BYTES);

    // FSM state register.
    always_ff @(posedge CLK_IN or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state: a new trigger always wins (restart), else finish on last accept.
    always_comb begin
        state_nxt = state;
        if (trigger)
            state_nxt = (LINE_WORDS != '0) ? ISSUE : IDLE;
        else if (accept && last)
            state_nxt = IDLE;
    end

    // Line bookkeeping; later assignments override, so a trigger restarts
    // after any same-cycle accept has already been applied.
    always_ff @(posedge CLK_IN or posedge reset) begin
        if (reset) begin
            cur_addr   <= '0;
            next_addr  <= '0;
            words_left <= '0;
            line_cnt   <= '0;
            LINE_NUM   <= '0;
            LINE_DONE  <= 1'b0;
            LATE_ERR   <= 1'b0;
        end else begin
            LINE_DONE <= (accept && last) || (trigger && LINE_WORDS == '0);
            if (frame_start) begin
                next_addr <= BASE_ADDR;
                line_cnt  <= '0;
            end
            if (accept) begin
                words_left <= words_left - HC_BITS'(CMD_len);
                cur_addr   <= cur_addr + step;
            end
            if (trigger) begin
                cur_addr   <= line_addr;
                words_left <= LINE_WORDS;
                next_addr  <= line_addr + LINE_STRIDE;
                LINE_NUM   <= line_idx;
                line_cnt   <= line_idx + 1'b1;
                if (state == ISSUE) LATE_ERR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_brianhg_gfx_line_fetch.sv
// Directed, table-driven bench for brianhg_gfx_line_fetch.
module tb_brianhg_gfx_line_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        h_ena = 1'b0;
    logic        v_ena = 1'b0;
    logic [31:0] base_addr = 32'h1000;
    logic [31:0] stride = 32'h800;
    logic [15:0] line_words = 16'd80;
    logic        cmd_req;
    logic [31:0] cmd_addr;
    logic [8:0]  cmd_len;
    logic        cmd_ready = 1'b0;
    logic        busy, line_done, late_err;
    logic [15:0] line_num;

    int checks = 0;
    int errors = 0;

    brianhg_gfx_line_fetch dut (
        .CLK_IN      (clk),
        .reset       (rst),
        .ENABLE      (enable),
        .H_ena       (h_ena),
        .V_ena       (v_ena),
        .BASE_ADDR   (base_addr),
        .LINE_STRIDE (stride),
        .LINE_WORDS  (line_words),
        .CMD_req     (cmd_req),
        .CMD_addr    (cmd_addr),
        .CMD_len     (cmd_len),
        .CMD_ready   (cmd_ready),
        .BUSY        (busy),
        .LINE_DONE   (line_done),
        .LINE_NUM    (line_num),
        .LATE_ERR    (late_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic [8:0]  len;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(logic rdy, logic rq, logic [31:0] a, logic [8:0] l,
                                logic b, logic d);
        vec_t v;
        v.ready = rdy; v.req = rq; v.addr = a; v.len = l; v.busy = b; v.done = d;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check each vector's outputs in the current cycle, then drive its ready.
    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            check("CMD_req", i, 32'(cmd_req), 32'(vecs[i].req));
            if (vecs[i].req) begin
                check("CMD_addr", i, cmd_addr, vecs[i].addr);
                check("CMD_len", i, 32'(cmd_len), 32'(vecs[i].len));
            end
            check("BUSY", i, 32'(busy), 32'(vecs[i].busy));
            check("LINE_DONE", i, 32'(line_done), 32'(vecs[i].done));
            cmd_ready = vecs[i].ready;
            tick();
        end
    endtask

    // Pulse H_ena high for one cycle then low; the falling edge triggers.
    task automatic next_line();
        h_ena = 1'b1;
        tick();
        h_ena = 1'b0;
        tick();
    endtask

    initial begin
        // line 0: 80 words from 0x1000, ready always high
        vecs[0]  = mk(1, 1, 32'h1000, 32, 1, 0);
        vecs[1]  = mk(1, 1, 32'h1200, 32, 1, 0);
        vecs[2]  = mk(1, 1, 32'h1400, 16, 1, 0);
        vecs[3]  = mk(1, 0, 32'h0,     0, 0, 1);
        vecs[4]  = mk(1, 0, 32'h0,     0, 0, 0);
        // line 1 at 0x1800, ready toggling
        vecs[5]  = mk(0, 1, 32'h1800, 32, 1, 0);
        vecs[6]  = mk(1, 1, 32'h1800, 32, 1, 0);
        vecs[7]  = mk(0, 1, 32'h1a00, 32, 1, 0);
        vecs[8]  = mk(1, 1, 32'h1a00, 32, 1, 0);
        vecs[9]  = mk(0, 1, 32'h1c00, 16, 1, 0);
        vecs[10] = mk(1, 1, 32'h1c00, 16, 1, 0);
        vecs[11] = mk(1, 0, 32'h0,     0, 0, 1);
        vecs[12] = mk(1, 0, 32'h0,     0, 0, 0);
        // line 2: zero words
        vecs[13] = mk(1, 0, 32'h0,     0, 0, 1);
        vecs[14] = mk(1, 0, 32'h0,     0, 0, 0);
        // line 4 after late restart: 40 words from 0x3000
        vecs[15] = mk(1, 1, 32'h3000, 32, 1, 0);
        vecs[16] = mk(1, 1, 32'h3200,  8, 1, 0);
        vecs[17] = mk(1, 0, 32'h0,     0, 0, 1);
        vecs[18] = mk(1, 0, 32'h0,     0, 0, 0);
        // after reset: 16 words from 0x4000
        vecs[19] = mk(1, 1, 32'h4000, 16, 1, 0);
        vecs[20] = mk(1, 0, 32'h0,     0, 0, 1);
        vecs[21] = mk(1, 0, 32'h0,     0, 0, 0);

        // reset values
        tick();
        check("rst CMD_req", 0, 32'(cmd_req), 0);
        check("rst CMD_addr", 0, cmd_addr, 0);
        check("rst CMD_len", 0, 32'(cmd_len), 0);
        check("rst BUSY", 0, 32'(busy), 0);
        check("rst LINE_DONE", 0, 32'(line_done), 0);
        check("rst LINE_NUM", 0, 32'(line_num), 0);
        check("rst LATE_ERR", 0, 32'(late_err), 0);

        // frame start coincident with first trigger
        h_ena = 1'b1;
        rst = 1'b0;
        tick();
        h_ena = 1'b0;
        v_ena = 1'b1;
        tick();
        run_vecs(0, 4);
        check("line0 LINE_NUM", 0, 32'(line_num), 0);

        // second line with stride, ready toggling
        next_line();
        check("line1 LINE_NUM", 1, 32'(line_num), 1);
        run_vecs(5, 12);

        // zero-length line
        line_words = 16'd0;
        next_line();
        run_vecs(13, 14);
        check("line2 LINE_NUM", 2, 32'(line_num), 2);

        // stalled line overrun by the next trigger
        line_words = 16'd80;
        cmd_ready = 1'b0;
        next_line();
        check("line3 CMD_req", 3, 32'(cmd_req), 1);
        check("line3 CMD_addr", 3, cmd_addr, 32'h2800);
        check("line3 LINE_NUM", 3, 32'(line_num), 3);
        tick();
        tick();
        check("line3 held addr", 3, cmd_addr, 32'h2800);
        check("line3 held len", 3, 32'(cmd_len), 32);
        line_words = 16'd40;
        h_ena = 1'b1;
        tick();
        check("pre-late LATE_ERR", 3, 32'(late_err), 0);
        h_ena = 1'b0;
        tick();
        check("late LATE_ERR", 4, 32'(late_err), 1);
        check("late LINE_NUM", 4, 32'(line_num), 4);
        check("late LINE_DONE", 4, 32'(line_done), 0);
        run_vecs(15, 18);
        check("sticky LATE_ERR", 4, 32'(late_err), 1);

        // asynchronous reset in the middle of a line
        line_words = 16'd80;
        cmd_ready = 1'b0;
        next_line();
        check("line5 CMD_req", 5, 32'(cmd_req), 1);
        check("line5 CMD_addr", 5, cmd_addr, 32'h3800);
        #2 rst = 1'b1;
        #1;
        check("async CMD_req", 5, 32'(cmd_req), 0);
        check("async BUSY", 5, 32'(busy), 0);
        check("async LATE_ERR", 5, 32'(late_err), 0);
        check("async CMD_addr", 5, cmd_addr, 0);
        v_ena = 1'b0;
        h_ena = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        base_addr = 32'h4000;
        line_words = 16'd16;
        tick();
        h_ena = 1'b0;
        v_ena = 1'b1;
        tick();
        run_vecs(19, 21);
        check("restart LINE_NUM", 0, 32'(line_num), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
